// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes, access sizes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Undefined funct3 codes fall back to a signed word access.
   function automatic lsu_size_t f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         F3_W:        return SZ_W;
         default:     return SZ_W;
      endcase
   endfunction

   function automatic logic f3_unsigned(input logic [2:0] f3);
      return (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Latency: n/a (signal bundle). Ports: req/we/addr/be/wdata out of master, gnt/rvalid/rdata into it.
// Backpressure: master holds bus_req and payload until bus_gnt; read data returns on bus_rvalid.
interface lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables / lane replication, misalign check, load lane select + extension.
// Latency: purely combinational. Ports: i_st_* current instruction in, o_be/o_wdata/o_misaligned out;
// Backpressure: none. i_ld_* latched access + raw bus data in, o_ld_data extended load value out.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_acc,
   input  logic [2:0]  i_st_funct3,
   input  logic [1:0]  i_st_addr_lo,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data
);

   lsu_size_t   w_st_size;
   lsu_size_t   w_ld_size;
   logic        w_ld_uns;
   logic [31:0] w_lane;

   assign w_st_size = f3_size(i_st_funct3);
   assign w_ld_size = f3_size(i_ld_funct3);
   assign w_ld_uns  = f3_unsigned(i_ld_funct3);

   // Sub-word stores replicate the data across all lanes so the addressed
   // lane carries it whatever the offset; the byte enables pick the lane.
   always_comb begin
      o_be         = 4'hF;
      o_wdata      = i_st_data;
      o_misaligned = 1'b0;
      case (w_st_size)
         SZ_B: begin
            o_be    = 4'b0001 << i_st_addr_lo;
            o_wdata = {4{i_st_data[7:0]}};
         end
         SZ_H: begin
            o_be         = 4'b0011 << i_st_addr_lo;
            o_wdata      = {2{i_st_data[15:0]}};
            o_misaligned = i_st_addr_lo[0];
         end
         default: begin
            o_misaligned = |i_st_addr_lo;
         end
      endcase
      o_misaligned = o_misaligned & i_acc;
   end

   // Shift the addressed lane down to bit 0, then extend.
   assign w_lane = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

   always_comb begin
      o_ld_data = w_lane;
      case (w_ld_size)
         SZ_B: o_ld_data = w_ld_uns ? {24'h0, w_lane[7:0]}
                                    : {{24{w_lane[7]}}, w_lane[7:0]};
         SZ_H: o_ld_data = w_ld_uns ? {16'h0, w_lane[15:0]}
                                    : {{16{w_lane[15]}}, w_lane[15:0]};
         default: o_ld_data = w_lane;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bridges the single-cycle datapath to the req/gnt/rvalid data bus, stalling the core meanwhile.
// Latency: write or zero-latency read = 2 stall cycles + DONE; read with N-cycle rvalid = 2+N; timeout after TIMEOUT_CYCLES.
// Backpressure: bus_req held until bus_gnt; Stall holds PC/RegWrite while a transaction is in flight.
// Ports: clk/rst; core side MemRead/MemWrite/funct3/ALUResult/WriteData in, ReadData/Stall/Misaligned/BusErr out; bus via lsu_if.master.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Misaligned,
   output logic        BusErr,
   lsu_if.master       bus
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   lsu_state_t  r_state;
   lsu_state_t  w_next;

   logic          r_we;
   logic [31:0]   r_addr;
   logic [2:0]    r_funct3;
   logic [3:0]    r_be;
   logic [31:0]   r_wdata;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata;
   logic          r_buserr;

   logic          w_acc;
   logic          w_start;
   logic          w_capture;
   logic          w_timeout;
   logic          w_cnt_max;
   logic          w_busy;
   logic          w_busy_next;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_ld_data;

   assign w_acc = MemRead | MemWrite;

   lsu_align u_align (
      .i_acc        (w_acc),
      .i_st_funct3  (funct3),
      .i_st_addr_lo (ALUResult[1:0]),
      .i_st_data    (WriteData),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (Misaligned),
      .i_ld_funct3  (r_funct3),
      .i_ld_addr_lo (r_addr[1:0]),
      .i_ld_rdata   (bus.bus_rdata),
      .o_ld_data    (w_ld_data)
   );

   assign w_cnt_max   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_busy      = (r_state == S_REQ) || (r_state == S_WAIT);
   assign w_busy_next = (w_next == S_REQ) || (w_next == S_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Completion is checked before the timeout so a grant or rvalid landing
   // in the last allowed cycle still completes normally.
   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_acc && !Misaligned) begin
               w_start = 1'b1;
               w_next  = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.bus_gnt && r_we) begin
               w_next = S_DONE;
            end else if (bus.bus_gnt && bus.bus_rvalid) begin
               w_capture = 1'b1;
               w_next    = S_DONE;
            end else if (w_cnt_max) begin
               w_timeout = 1'b1;
               w_next    = S_DONE;
            end else if (bus.bus_gnt) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.bus_rvalid) begin
               w_capture = 1'b1;
               w_next    = S_DONE;
            end else if (w_cnt_max) begin
               w_timeout = 1'b1;
               w_next    = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_addr   <= 32'h0;
         r_funct3 <= 3'b000;
         r_be     <= 4'h0;
         r_wdata  <= 32'h0;
         r_cnt    <= '0;
         r_rdata  <= 32'h0;
         r_buserr <= 1'b0;
      end else begin
         if (w_start) begin
            r_we     <= MemWrite;
            r_addr   <= ALUResult;
            r_funct3 <= funct3;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
         end
         // Counts REQ+WAIT cycles of the current access; zero on entry to REQ
         // and cleared as soon as the access leaves the bus phase.
         if (w_busy && w_busy_next) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end
         if (w_capture) begin
            r_rdata <= w_ld_data;
         end else if (w_timeout) begin
            r_rdata <= 32'h0;
         end
         // Only ever high during the DONE cycle of an aborted access.
         r_buserr <= w_timeout;
      end
   end

   assign bus.bus_req   = (r_state == S_REQ);
   assign bus.bus_we    = r_we;
   assign bus.bus_addr  = {r_addr[31:2], 2'b00};
   assign bus.bus_be    = r_be;
   assign bus.bus_wdata = r_wdata;

   assign Stall    = ((r_state == S_IDLE) && w_acc && !Misaligned) || w_busy;
   assign ReadData = r_rdata;
   assign BusErr   = r_buserr;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses vs a byte-level model.
// Latency: n/a. Acts as both the core (holds the instruction until it retires) and the memory (gnt/rvalid delays).
// Backpressure: memory grants after a chosen number of REQ cycles and returns rvalid after a chosen delay.
module tb_load_store_unit;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Misaligned;
   logic        BusErr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu_if u_bus ();

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .ALUResult  (ALUResult),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .Stall      (Stall),
      .Misaligned (Misaligned),
      .BusErr     (BusErr),
      .bus        (u_bus.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (byte-level view of the access) ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] f3);
      int a = int'(addr[1:0]);
      int n = size_of(f3);
      logic [3:0] be = 4'h0;
      for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + n);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f3);
      int n = size_of(f3);
      logic [31:0] v = 32'h0;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
      return v;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] f3);
      int a = int'(addr[1:0]);
      int n = size_of(f3);
      bit uns = (f3 == 3'b100) || (f3 == 3'b101);
      logic [31:0] v = 32'h0;
      logic sgn;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(a+i) +: 8];
      sgn = uns ? 1'b0 : v[8*n-1];
      for (int i = n; i < 4; i++) v[8*i +: 8] = {8{sgn}};
      return v;
   endfunction

   // Issue one instruction and play memory until it retires.
   // gdly: REQ cycles without grant; rdly: WAIT cycles until rvalid; norv: never send rvalid.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                             input int gdly, input int rdly, input bit norv);
      bit acc = rd | wr;
      bit we = wr;
      int n = size_of(f3);
      bit mis = acc && ((addr % n) != 0);
      int req_cyc = 0;
      int wait_cyc = 0;
      int stall_cnt = 0;
      int exp_stall;
      bit granted = 1'b0;
      bit done = 1'b0;
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
      u_bus.bus_rdata = rdata; u_bus.bus_gnt = 1'b0; u_bus.bus_rvalid = 1'b0;
      @(negedge clk);
      check("misaligned", Misaligned, mis);
      check("stall_idle", Stall, acc && !mis);
      check("req_idle", u_bus.bus_req, 0);
      if (!acc || mis) begin
         @(posedge clk); #1;
         check("no_req_after", u_bus.bus_req, 0);
         return;
      end
      stall_cnt = 1;
      exp_stall = norv ? (1 + TMO) : (1 + gdly + 1 + (we ? 0 : rdly));
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(posedge clk); #1;
         u_bus.bus_gnt = 1'b0;
         u_bus.bus_rvalid = 1'b0;
         if (u_bus.bus_req) begin
            req_cyc++;
            if (req_cyc == 1) begin
               check("bus_addr", u_bus.bus_addr, addr & 32'hFFFF_FFFC);
               check("bus_we", u_bus.bus_we, we);
               if (we) begin
                  check("bus_be", u_bus.bus_be, model_be(addr, f3));
                  check("bus_wdata", u_bus.bus_wdata, model_wdata(wd, f3));
               end
            end
            if (req_cyc > gdly) begin
               u_bus.bus_gnt = 1'b1;
               granted = 1'b1;
               if (!we && rdly == 0 && !norv) u_bus.bus_rvalid = 1'b1;
            end
         end else if (granted && !we) begin
            wait_cyc++;
            if (!norv && wait_cyc == rdly) u_bus.bus_rvalid = 1'b1;
         end
         @(negedge clk);
         if (!Stall) begin
            done = 1'b1;
            check("stall_cycles", stall_cnt, exp_stall);
            check("req_done", u_bus.bus_req, 0);
            check("buserr", BusErr, norv);
            if (!we) check("readdata", ReadData, norv ? 32'h0 : model_load(rdata, addr, f3));
         end else begin
            stall_cnt++;
         end
      end
      if (!done) check("done_seen", stall_cnt, exp_stall);
   endtask

   task automatic idle_core();
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      u_bus.bus_gnt = 1'b0; u_bus.bus_rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; ALUResult = 32'h0; WriteData = 32'h0;
      u_bus.bus_gnt = 1'b0; u_bus.bus_rvalid = 1'b0; u_bus.bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_stall", Stall, 0);
      check("rst_req", u_bus.bus_req, 0);
      check("rst_rdata", ReadData, 0);
      check("rst_buserr", BusErr, 0);
      check("rst_addr", u_bus.bus_addr, 0);
      check("rst_mis", Misaligned, 0);
      rst = 1'b0;

      // 1: SW with grant on the second REQ cycle
      run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 0);
      // 2: SB to top lane, then LB / LBU from it
      run_access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 0);
      run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 0, 1, 0);
      run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 0, 0, 0);
      // 3: misaligned half and word loads
      run_access(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0);
      run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0);
      // 6: read+write together is a write; back-to-back zero-latency loads
      run_access(1, 1, 3'b010, 32'h200, 32'h11223344, 32'h0, 0, 0, 0);
      run_access(1, 0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 0, 0, 0);
      run_access(1, 0, 3'b001, 32'h206, 32'h0, 32'h8001_7FFF, 0, 0, 0);
      // 4: timeouts: granted but no rvalid, and never granted
      run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h55555555, 0, 0, 1);
      run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'h0, 100, 0, 1);
      idle_core();

      // 5: reset while waiting for rvalid; late rvalid must be ignored
      run_access(1, 0, 3'b010, 32'h308, 32'h0, 32'h0BADF00D, 0, 0, 0);
      @(posedge clk); #1;
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h400;
      u_bus.bus_rdata = 32'h12345678;
      @(posedge clk); #1;
      check("r5_req", u_bus.bus_req, 1);
      u_bus.bus_gnt = 1'b1;
      @(posedge clk); #1;
      u_bus.bus_gnt = 1'b0;
      check("r5_wait_stall", Stall, 1);
      #2;
      rst = 1'b1;
      MemRead = 1'b0;
      #1;
      check("r5_req_rst", u_bus.bus_req, 0);
      check("r5_stall_rst", Stall, 0);
      check("r5_rdata_rst", ReadData, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      u_bus.bus_rvalid = 1'b1;
      @(posedge clk); #1;
      u_bus.bus_rvalid = 1'b0;
      @(negedge clk);
      check("r5_late_rvalid", ReadData, 0);
      check("r5_late_req", u_bus.bus_req, 0);

      // randomized accesses
      for (int k = 0; k < 200; k++) begin
         run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
      end
      idle_core();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
